gb_cpu_regfile_mp: RTL and testbench
====================================

GB_CPU_REGFILE_MP -- requirements
Module: gb_cpu_regfile_mp

Interface
REQ-001 SHALL have parameter NUM_REGS, 16, number of DATA_W-bit registers (even, >=4).
REQ-002 SHALL have parameter DATA_W, 8, register width in bits.
REQ-003 SHALL have parameter NUM_WR, 3, write ports; lower index has higher priority.
REQ-004 SHALL have parameter NUM_RD, 2, combinational read ports.
REQ-005 SHALL have parameter SNAP_DEPTH, 2, context-snapshot stack depth (>=1).
REQ-006 SHALL have parameter BYPASS, 1, read ports forward same-cycle write data when 1.
REQ-007 SHALL have port clk, input, 1, machine clock, posedge active.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port wr_en, input, NUM_WR, per-port write enable.
REQ-010 SHALL have port wr_pair, input, NUM_WR, per-port 16-bit pair mode.
REQ-011 SHALL have port wr_addr, input, NUM_WR x AW (AW = clog2(NUM_REGS)), target register.
REQ-012 SHALL have port wr_data, input, NUM_WR x 2*DATA_W, write data; byte mode uses low DATA_W bits.
REQ-013 SHALL have port rd_addr, input, NUM_RD x AW, read address.
REQ-014 SHALL have port rd_data, output, NUM_RD x DATA_W, read data.
REQ-015 SHALL have port regs, output, NUM_REGS x DATA_W, flat view of all registers.
REQ-016 SHALL have ports snap_push and snap_pop, input, 1 each, save/restore whole file.
REQ-017 SHALL have ports snap_full and snap_empty, output, 1 each, stack status.
REQ-018 SHALL have port snap_count, output, clog2(SNAP_DEPTH+1), stored snapshots.
REQ-019 SHALL have port snap_err, output, 1, one-cycle pulse on an illegal snapshot request.

Function
REQ-020 Byte write SHALL update register wr_addr at the next posedge.
REQ-021 Pair write SHALL write wr_data[2*DATA_W-1:DATA_W] to register {wr_addr[AW-1:1],0} (hi) and low half to {wr_addr[AW-1:1],1} (lo); wr_addr[0] is ignored.
REQ-022 Conflicts SHALL resolve per register: the lowest-index enabled port touching that register wins; other registers of a losing pair write still update.
REQ-023 rd_data SHALL be combinational from the current registers; with BYPASS=1 it SHALL instead return the winning same-cycle write value for that address.
REQ-024 snap_push (legal: not full, no pop) SHALL copy all pre-write register values into stack slot snap_count and increment snap_count at the posedge.
REQ-025 snap_pop (legal: not empty, no push) SHALL restore all registers from slot snap_count-1 and decrement snap_count.
REQ-026 Writes in the same cycle as a pop SHALL be applied on top of the restored values (writes win).
REQ-027 Push when full, pop when empty, or push and pop together SHALL leave stack and count unchanged, still apply writes, and assert snap_err for exactly the next cycle.
REQ-028 snap_full SHALL equal (snap_count==SNAP_DEPTH); snap_empty SHALL equal (snap_count==0); both combinational from the count.
REQ-029 Registers with no write and no pop SHALL hold their value.

Reset
REQ-030 Reset assertion SHALL asynchronously clear all registers, snap_count and snap_err to 0 (snap_empty=1, snap_full=0).
REQ-031 Stack slot contents SHALL need no reset; a push or pop in progress when reset asserts SHALL be discarded.
REQ-032 The first posedge after reset deassertion SHALL accept writes and snapshot requests normally.

Structure
REQ-033 Parameter defaults and the pair hi/lo index helper functions SHALL live in gb_cpu_common_pkg.
REQ-034 The snapshot stack (storage, count, full/empty, error pulse) SHALL be sub-module gb_cpu_regfile_snapstack.
REQ-035 All state SHALL update on posedge clk only; no negedge logic.

Verification
REQ-036 Port0 byte write r3=0x5A, port1 byte write r3=0xA5 same cycle -> r3=0x5A; with BYPASS=1, rd_addr=3 reads 0x5A in that cycle.
REQ-037 Port1 pair write addr=5 data=0x1234 -> r4=0x12, r5=0x34 next cycle; concurrent port0 byte r5=0xFF -> r4=0x12, r5=0xFF.
REQ-038 Fill file, push, overwrite r0=0x77 with pop same cycle -> all regs restored except r0=0x77; snap_count 1->0.
REQ-039 SNAP_DEPTH=2: three pushes -> snap_count=2, snap_full=1, snap_err pulses once on third push; pop on empty -> snap_err pulse, count stays 0.
REQ-040 Push and pop same cycle with count=1 -> count stays 1, registers unchanged, snap_err=1 for one cycle.
REQ-041 Assert reset mid-cycle between edges -> regs, snap_count, snap_err read 0 immediately, before the next posedge.

Source files
------------

// File: rtl/gb_cpu_common_pkg.sv
// Shared defaults and register-pair index helpers for the GB CPU register file.
package gb_cpu_common_pkg;

   localparam int GB_NUM_REGS   = 16;
   localparam int GB_DATA_W     = 8;
   localparam int GB_NUM_WR     = 3;
   localparam int GB_NUM_RD     = 2;
   localparam int GB_SNAP_DEPTH = 2;
   localparam int GB_BYPASS     = 1;

   // Even register of a pair holds the high byte, odd register the low byte.
   function automatic int pair_hi_idx(input int addr);
      return addr & ~1;
   endfunction

   function automatic int pair_lo_idx(input int addr);
      return addr | 1;
   endfunction

endpackage

// File: rtl/gb_cpu_regfile_snapstack.sv
// Whole-file context snapshot stack with count, full/empty flags and error pulse.
module gb_cpu_regfile_snapstack
   import gb_cpu_common_pkg::*;
#(
   parameter int  NUM_REGS   = GB_NUM_REGS,
   parameter int  DATA_W     = GB_DATA_W,
   parameter int  SNAP_DEPTH = GB_SNAP_DEPTH,
   localparam int FW         = NUM_REGS * DATA_W,
   localparam int CW         = $clog2(SNAP_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [FW-1:0] cur_regs,
   output logic          restore_en,
   output logic [FW-1:0] restore_regs,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          err
);

   logic [FW-1:0] slot_q [SNAP_DEPTH];
   logic [FW-1:0] slot_d [SNAP_DEPTH];
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;
   logic          push_ok;

   assign full       = (count_q == CW'(SNAP_DEPTH));
   assign empty      = (count_q == '0);
   assign push_ok    = push && !pop && !full;
   assign restore_en = pop && !push && !empty;
   assign count      = count_q;
   assign err        = err_q;

   always_comb begin
      slot_d       = slot_q;
      count_d      = count_q;
      restore_regs = '0;
      err_d        = (push || pop) && !push_ok && !restore_en;
      for (int s = 0; s < SNAP_DEPTH; s++) begin
         if (push_ok && (count_q == CW'(s)))
            slot_d[s] = cur_regs;
         if (restore_en && (count_q == CW'(s + 1)))
            restore_regs = slot_q[s];
      end
      if (push_ok)
         count_d = count_q + CW'(1);
      else if (restore_en)
         count_d = count_q - CW'(1);
   end

   // Slot storage is only meaningful below count_q, so it carries no reset.
   always_ff @(posedge clk) begin
      slot_q <= slot_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: rtl/gb_cpu_regfile_mp.sv
// Multi-port GB CPU register file with 16-bit pair writes, read bypass and context snapshots.
module gb_cpu_regfile_mp
   import gb_cpu_common_pkg::*;
#(
   parameter int  NUM_REGS   = GB_NUM_REGS,
   parameter int  DATA_W     = GB_DATA_W,
   parameter int  NUM_WR     = GB_NUM_WR,
   parameter int  NUM_RD     = GB_NUM_RD,
   parameter int  SNAP_DEPTH = GB_SNAP_DEPTH,
   parameter int  BYPASS     = GB_BYPASS,
   localparam int AW         = $clog2(NUM_REGS),
   localparam int FW         = NUM_REGS * DATA_W,
   localparam int CW         = $clog2(SNAP_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_WR-1:0]          wr_en,
   input  logic [NUM_WR-1:0]          wr_pair,
   input  logic [NUM_WR*AW-1:0]       wr_addr,
   input  logic [NUM_WR*2*DATA_W-1:0] wr_data,
   input  logic [NUM_RD*AW-1:0]       rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [FW-1:0]              regs,
   input  logic                       snap_push,
   input  logic                       snap_pop,
   output logic                       snap_full,
   output logic                       snap_empty,
   output logic [CW-1:0]              snap_count,
   output logic                       snap_err
);

   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [DATA_W-1:0]   wr_val [NUM_REGS];
   logic [NUM_REGS-1:0] wr_hit;
   logic                restore_en;
   logic [FW-1:0]       restore_regs;

   // Walk ports from highest to lowest index so the lowest enabled port lands last.
   always_comb begin
      wr_hit = '0;
      for (int r = 0; r < NUM_REGS; r++)
         wr_val[r] = '0;
      for (int p = NUM_WR - 1; p >= 0; p--) begin
         if (wr_en[p]) begin
            for (int r = 0; r < NUM_REGS; r++) begin
               if (wr_pair[p] && (r == pair_hi_idx(int'(wr_addr[p*AW +: AW])))) begin
                  wr_hit[r] = 1'b1;
                  wr_val[r] = wr_data[p*2*DATA_W + DATA_W +: DATA_W];
               end else if (wr_pair[p] && (r == pair_lo_idx(int'(wr_addr[p*AW +: AW])))) begin
                  wr_hit[r] = 1'b1;
                  wr_val[r] = wr_data[p*2*DATA_W +: DATA_W];
               end else if (!wr_pair[p] && (r == int'(wr_addr[p*AW +: AW]))) begin
                  wr_hit[r] = 1'b1;
                  wr_val[r] = wr_data[p*2*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   // A restore forms the base image; same-cycle writes are layered on top of it.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = restore_en ? restore_regs[r*DATA_W +: DATA_W] : regs_q[r];
         if (wr_hit[r])
            regs_d[r] = wr_val[r];
      end
   end

   always_comb begin
      rd_data = '0;
      for (int q = 0; q < NUM_RD; q++) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (int'(rd_addr[q*AW +: AW]) == r)
               rd_data[q*DATA_W +: DATA_W] = ((BYPASS != 0) && wr_hit[r]) ? wr_val[r] : regs_q[r];
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++)
            regs_q[r] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   gb_cpu_regfile_snapstack #(
      .NUM_REGS   (NUM_REGS),
      .DATA_W     (DATA_W),
      .SNAP_DEPTH (SNAP_DEPTH)
   ) u_snapstack (
      .clk          (clk),
      .reset        (reset),
      .push         (snap_push),
      .pop          (snap_pop),
      .cur_regs     (regs),
      .restore_en   (restore_en),
      .restore_regs (restore_regs),
      .count        (snap_count),
      .full         (snap_full),
      .empty        (snap_empty),
      .err          (snap_err)
   );

endmodule

// File: tb/tb_gb_cpu_regfile_mp.sv
// Scoreboard bench for gb_cpu_regfile_mp: a behavioural model queues expectations per cycle.
module tb_gb_cpu_regfile_mp;

   localparam int NR = 16;
   localparam int DW = 8;
   localparam int NW = 3;
   localparam int ND = 2;
   localparam int SD = 2;
   localparam int AW = 4;

   typedef logic [127:0] vec_t;
   typedef struct {
      string tag;
      vec_t  exp;
   } sb_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     wr_en, wr_pair;
   logic [NW*AW-1:0]  wr_addr;
   logic [NW*16-1:0]  wr_data;
   logic [ND*AW-1:0]  rd_addr;
   logic [ND*DW-1:0]  rd_data;
   logic [NR*DW-1:0]  regs;
   logic              snap_push, snap_pop;
   logic              snap_full, snap_empty;
   logic [1:0]        snap_count;
   logic              snap_err;

   always #5 clk = ~clk;

   gb_cpu_regfile_mp #(
      .NUM_REGS(NR), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(ND), .SNAP_DEPTH(SD), .BYPASS(1)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_pair(wr_pair), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .regs(regs),
      .snap_push(snap_push), .snap_pop(snap_pop), .snap_full(snap_full),
      .snap_empty(snap_empty), .snap_count(snap_count), .snap_err(snap_err)
   );

   int   n_vec  = 0;
   int   n_miss = 0;
   sb_t  sbq[$];

   logic [7:0] m [NR];
   logic [7:0] st [SD][NR];
   int         cnt;
   logic       merr;
   logic [7:0] wv [NR];
   bit         wh [NR];

   task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_push(input string tag, input vec_t v);
      sb_t e;
      e.tag = tag;
      e.exp = v;
      sbq.push_back(e);
   endtask

   task automatic sb_pop(input vec_t got);
      sb_t e;
      if (sbq.size() == 0) begin
         n_vec++;
         n_miss++;
         $display("FAIL sb_underflow got=%0h exp=none", got);
      end else begin
         e = sbq.pop_front();
         check_eq(e.tag, got, e.exp);
      end
   endtask

   task automatic clear_inputs();
      wr_en = '0; wr_pair = '0; wr_addr = '0; wr_data = '0;
      rd_addr = '0; snap_push = 1'b0; snap_pop = 1'b0;
   endtask

   task automatic model_reset();
      for (int r = 0; r < NR; r++) m[r] = 8'h00;
      cnt  = 0;
      merr = 1'b0;
   endtask

   task automatic wbyte(input int p, input int a, input logic [7:0] d);
      wr_en[p]              = 1'b1;
      wr_pair[p]            = 1'b0;
      wr_addr[p*AW +: AW]   = a[AW-1:0];
      wr_data[p*16 +: 16]   = {8'h00, d};
   endtask

   task automatic wpair(input int p, input int a, input logic [15:0] d);
      wr_en[p]              = 1'b1;
      wr_pair[p]            = 1'b1;
      wr_addr[p*AW +: AW]   = a[AW-1:0];
      wr_data[p*16 +: 16]   = d;
   endtask

   task automatic claim(input int i, input logic [7:0] v);
      if (!wh[i]) begin
         wh[i] = 1'b1;
         wv[i] = v;
      end
   endtask

   // First enabled port in ascending order claims each register.
   task automatic resolve();
      for (int r = 0; r < NR; r++) begin
         wh[r] = 1'b0;
         wv[r] = 8'h00;
      end
      for (int p = 0; p < NW; p++) begin
         if (wr_en[p]) begin
            int a;
            logic [15:0] d;
            a = int'(wr_addr[p*AW +: AW]);
            d = wr_data[p*16 +: 16];
            if (wr_pair[p]) begin
               claim(a - (a % 2), d[15:8]);
               claim(a - (a % 2) + 1, d[7:0]);
            end else begin
               claim(a, d[7:0]);
            end
         end
      end
   endtask

   task automatic push_state(input string tag);
      vec_t flat;
      flat = '0;
      for (int r = 0; r < NR; r++) flat[r*8 +: 8] = m[r];
      sb_push($sformatf("%s_regs", tag), flat);
      sb_push($sformatf("%s_count", tag), vec_t'(cnt));
      sb_push($sformatf("%s_err", tag), vec_t'(merr));
      sb_push($sformatf("%s_full", tag), vec_t'(cnt == SD));
      sb_push($sformatf("%s_empty", tag), vec_t'(cnt == 0));
   endtask

   task automatic pop_state();
      sb_pop(vec_t'(regs));
      sb_pop(vec_t'(snap_count));
      sb_pop(vec_t'(snap_err));
      sb_pop(vec_t'(snap_full));
      sb_pop(vec_t'(snap_empty));
   endtask

   // Inputs are set by the caller just after an edge; this checks reads, clocks once, checks state.
   task automatic cycle(input string tag);
      bit lpush, lpop;
      #1;
      resolve();
      for (int q = 0; q < ND; q++) begin
         int a;
         a = int'(rd_addr[q*AW +: AW]);
         sb_push($sformatf("%s_rd%0d", tag, q), vec_t'(wh[a] ? wv[a] : m[a]));
         sb_pop(vec_t'(rd_data[q*8 +: 8]));
      end
      lpush = snap_push && !snap_pop && (cnt < SD);
      lpop  = snap_pop && !snap_push && (cnt > 0);
      merr  = (snap_push || snap_pop) && !lpush && !lpop;
      if (lpush) begin
         for (int r = 0; r < NR; r++) st[cnt][r] = m[r];
         cnt++;
      end else if (lpop) begin
         for (int r = 0; r < NR; r++) m[r] = st[cnt-1][r];
         cnt--;
      end
      for (int r = 0; r < NR; r++) if (wh[r]) m[r] = wv[r];
      push_state(tag);
      @(posedge clk);
      #1;
      pop_state();
      clear_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      clear_inputs();
      model_reset();
      #3;
      push_state("rst");
      pop_state();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Same-register byte conflict: port 0 wins, bypass shows winner.
      wbyte(0, 3, 8'h5A); wbyte(1, 3, 8'hA5); rd_addr[3:0] = 4'd3;
      cycle("conf");
      check_eq("r3_const", vec_t'(regs[3*8 +: 8]), vec_t'(8'h5A));

      wpair(1, 5, 16'h1234); rd_addr[7:4] = 4'd4;
      cycle("pair");
      check_eq("r4_const", vec_t'(regs[4*8 +: 8]), vec_t'(8'h12));
      check_eq("r5_const", vec_t'(regs[5*8 +: 8]), vec_t'(8'h34));

      wpair(1, 5, 16'h1234); wbyte(0, 5, 8'hFF); rd_addr = {4'd4, 4'd5};
      cycle("pairconf");
      check_eq("r5_ff_const", vec_t'(regs[5*8 +: 8]), vec_t'(8'hFF));

      wpair(2, 9, 16'h1111); wbyte(1, 8, 8'h22); rd_addr = {4'd9, 4'd8};
      cycle("p2pair");

      for (int c = 0; c < 6; c++) begin
         for (int p = 0; p < NW; p++)
            if (c*3 + p < NR) wbyte(p, c*3 + p, 8'($urandom));
         cycle($sformatf("fill%0d", c));
      end

      snap_push = 1'b1;
      cycle("push1");
      wbyte(0, 1, 8'hC3); wbyte(1, 2, 8'h3C); wpair(2, 14, 16'hBEEF);
      cycle("dirty");
      snap_pop = 1'b1; wbyte(0, 0, 8'h77); rd_addr = {4'd1, 4'd0};
      cycle("popwr");
      check_eq("r0_77_const", vec_t'(regs[7:0]), vec_t'(8'h77));
      check_eq("cnt0_const", vec_t'(snap_count), vec_t'(0));

      for (int i = 0; i < 3; i++) begin
         snap_push = 1'b1;
         cycle($sformatf("push_x%0d", i));
      end
      check_eq("full_err_const", vec_t'({snap_count, snap_full, snap_err}), vec_t'(4'b1011));
      cycle("nop_a");
      for (int i = 0; i < 3; i++) begin
         snap_pop = 1'b1;
         cycle($sformatf("pop_x%0d", i));
      end
      check_eq("empty_err_const", vec_t'({snap_count, snap_empty, snap_err}), vec_t'(4'b0011));

      snap_push = 1'b1;
      cycle("push_b");
      snap_push = 1'b1; snap_pop = 1'b1;
      cycle("pushpop");
      check_eq("pushpop_const", vec_t'({snap_count, snap_err}), vec_t'(3'b011));
      cycle("nop_b");

      for (int i = 0; i < 60; i++) begin
         for (int p = 0; p < NW; p++) begin
            wr_en[p]            = 1'($urandom_range(0, 1));
            wr_pair[p]          = 1'($urandom_range(0, 1));
            wr_addr[p*AW +: AW] = AW'($urandom_range(0, NR-1));
            wr_data[p*16 +: 16] = 16'($urandom);
         end
         rd_addr   = 8'($urandom);
         snap_push = ($urandom_range(0, 5) == 0);
         snap_pop  = ($urandom_range(0, 5) == 0);
         cycle($sformatf("rnd%0d", i));
      end

      // Get a non-zero count and a pending error, then reset between edges.
      snap_push = 1'b1; wbyte(0, 6, 8'h66);
      cycle("prerst_a");
      snap_push = 1'b1; snap_pop = 1'b1;
      cycle("prerst_b");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      push_state("midrst");
      pop_state();
      check_eq("midrst_regs_const", vec_t'(regs), vec_t'(0));

      @(negedge clk);
      reset = 1'b0;
      wbyte(0, 2, 8'h42); snap_push = 1'b1;
      cycle("postrst");
      check_eq("postrst_const", vec_t'({regs[2*8 +: 8], snap_count}), vec_t'({8'h42, 2'd1}));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
